// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stage_reg
// Brief   : Inter-stage pipeline register with valid/ready, optional skid
//           entry, synchronous flush and saturating flushed-entry counter.
// Revision: 1.0
// ============================================================================
module pipe_stage_reg #(
    parameter int CTRL_W     = 4,
    parameter int DATA_W     = 32,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    state_t            state;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic              accept;
    logic              emit;
    logic [1:0]        drop;
    logic [CNT_W+1:0]  cnt_sum;
    logic [CNT_W-1:0]  cnt_next;

    // The skid variant keeps out_ready off the in_ready path entirely.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = !flush && (state != TWO);
        end else begin : g_direct_ready
            assign in_ready = !flush && (!out_valid || out_ready);
        end
    endgenerate

    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign out_ctrl  = head_ctrl;
    assign out_data  = head_data;

    // An entry emitted in the flush cycle was delivered, so it is not counted.
    assign drop     = occupancy - {1'b0, emit};
    assign cnt_sum  = {2'b00, flush_cnt} + {{CNT_W{1'b0}}, drop};
    assign cnt_next = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
            head_ctrl <= '0;
            head_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
            head_ctrl <= '0;
            skid_ctrl <= '0;
            flush_cnt <= cnt_next;
            if (CLEAR_DATA != 0) begin
                head_data <= '0;
                skid_data <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_ctrl <= in_ctrl;
                        head_data <= in_data;
                        state     <= ONE;
                        out_valid <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        head_ctrl <= in_ctrl;
                        head_data <= in_data;
                    end else if (accept && (SKID != 0)) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                        state     <= TWO;
                        occupancy <= 2'd2;
                    end else if (emit) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        occupancy <= 2'd0;
                    end
                end
                TWO: begin
                    if (emit) begin
                        head_ctrl <= skid_ctrl;
                        head_data <= skid_data;
                        state     <= ONE;
                        occupancy <= 2'd1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    occupancy <= 2'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_stage_reg
// Brief   : Bench for pipe_stage_reg; a skid/clearing instance and a
//           single-entry/holding instance share stimulus, each against a queue model.
// Revision: 1.0
// ============================================================================
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [3:0]  c;
        logic [31:0] d;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_ctrl;
    logic [31:0] in_data;
    logic        flush;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [3:0]  out_ctrl_a, out_ctrl_b;
    logic [31:0] out_data_a, out_data_b;
    logic [1:0]  occ_a, occ_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    ent_t q[2][$];
    ent_t lh[2];
    int   cnt[2];

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .SKID(1), .CLEAR_DATA(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_ctrl(out_ctrl_a), .out_data(out_data_a),
        .occupancy(occ_a), .flush_cnt(cnt_a)
    );

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .SKID(0), .CLEAR_DATA(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_ctrl(out_ctrl_b), .out_data(out_data_b),
        .occupancy(occ_b), .flush_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            q[i].delete();
            cnt[i] = 0;
            lh[i]  = '0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            string n;
            n = (i == 0) ? "a" : "b";
            chk({n, "_out_valid"}, (i == 0) ? out_valid_a : out_valid_b, q[i].size() > 0);
            chk({n, "_occupancy"}, (i == 0) ? occ_a : occ_b, q[i].size());
            chk({n, "_flush_cnt"}, (i == 0) ? cnt_a : {14'd0, cnt_b}, cnt[i]);
            chk({n, "_out_ctrl"}, (i == 0) ? out_ctrl_a : out_ctrl_b, lh[i].c);
            chk({n, "_out_data"}, (i == 0) ? out_data_a : out_data_b, lh[i].d);
        end
    endtask

    // One clock: check in_ready, apply the queue model at the edge, check outputs.
    task automatic tick();
        bit rdy[2];
        bit em[2];
        #1;
        for (int i = 0; i < 2; i++) begin
            int sz;
            sz = q[i].size();
            rdy[i] = !flush && ((i == 0) ? (sz < 2) : (sz == 0 || out_ready));
            em[i]  = (sz > 0) && out_ready;
            chk((i == 0) ? "a_in_ready" : "b_in_ready",
                (i == 0) ? in_ready_a : in_ready_b, rdy[i]);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (em[i]) void'(q[i].pop_front());
            if (flush) begin
                int mx;
                mx = (i == 0) ? 65535 : 3;
                cnt[i] = (cnt[i] + q[i].size() > mx) ? mx : cnt[i] + q[i].size();
                q[i].delete();
                lh[i].c = '0;
                if (i == 0) lh[i].d = '0;
            end else begin
                if (in_valid && rdy[i]) q[i].push_back({in_ctrl, in_data});
                if (q[i].size() > 0) lh[i] = q[i][0];
            end
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input bit r, input bit f, input logic [31:0] d);
        in_valid  = v;
        out_ready = r;
        flush     = f;
        in_data   = d;
        in_ctrl   = 4'($urandom_range(1, 15));
    endtask

    initial begin
        logic [1:0] sat_exp [6];
        int base;
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_outputs();
        chk("reset_in_ready_a", in_ready_a, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the 2-bit counter with one flushed entry per round.
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 0, $urandom);
            tick();
            drive(0, 0, 1, 32'h0);
            tick();
            chk("sat_cnt_b", cnt_b, sat_exp[k]);
        end

        // Full-rate streaming, one-cycle latency.
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1, 0, 32'(i));
            tick();
            chk("stream_a", out_data_a, 32'(i));
            chk("stream_b", out_data_b, 32'(i));
            chk("stream_occ", occ_a, 2'd1);
        end
        drive(0, 1, 0, 32'h0);
        tick();

        // Stall with two entries held.
        drive(1, 0, 0, 32'hA);
        tick();
        drive(1, 0, 0, 32'hB);
        tick();
        chk("stall_occ", occ_a, 2'd2);
        chk("stall_ready", in_ready_a, 1'b0);
        chk("stall_head", out_data_a, 32'hA);
        drive(0, 1, 0, 32'h0);
        tick();
        chk("release_second", out_data_a, 32'hB);
        tick();
        chk("release_empty", out_valid_a, 1'b0);

        // Flush with two held, stalled then draining.
        for (int r = 0; r < 2; r++) begin
            drive(1, 0, 0, $urandom);
            tick();
            tick();
            base = cnt[0];
            drive(0, r, 1, 32'h0);
            tick();
            chk("flush_cnt_delta", cnt_a, 16'(base + 2 - r));
            chk("flush_valid", out_valid_a, 1'b0);
            chk("flush_ctrl", out_ctrl_a, 4'h0);
        end

        // Flush coincident with an incoming entry.
        drive(1, 1, 1, 32'h55);
        tick();
        chk("flush_in_occ", occ_a, 2'd0);

        // Asynchronous reset between edges with two held.
        drive(1, 0, 0, $urandom);
        tick();
        tick();
        drive(0, 0, 0, 32'h0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("async_rst_ready_a", in_ready_a, 1'b1);
        chk("async_rst_ready_b", in_ready_b, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
